pixel_stream_scanner: RTL and testbench
=======================================

# pixel_stream_scanner

Raster-scan front end for the adaptive-thresholding pipeline. Generates the column/row coordinates that drive the input ROM reader, tracks the reader's fixed read latency, and re-emits each pixel with its coordinates as a valid/ready stream to the thresholding stage. A small credit-controlled FIFO absorbs downstream backpressure, so no returning pixel is ever dropped.

## Interface
Parameters:
- WIDTH_BITS, 8, log2 image width (256)
- HEIGHT_BITS, 8, log2 image height (256)
- READ_LATENCY, 2, cycles from coordinates presented to the reader until its data output reflects them
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ READ_LATENCY+2 for 1 pixel/cycle

Ports:
- clock  in  1  single clock; everything is on posedge
- reset  in  1  synchronous, active-high reset
- iStart  in  1  begin one frame scan; sampled only in IDLE
- oCol  out  WIDTH_BITS  column to the ROM reader
- oRow  out  HEIGHT_BITS  row to the ROM reader
- iData  in  8  pixel returned by the ROM reader
- oValid  out  1  output pixel valid
- iReady  in  1  downstream accepts the pixel
- oPixel  out  8  pixel value
- oX  out  WIDTH_BITS  pixel column
- oY  out  HEIGHT_BITS  pixel row
- oLast  out  1  qualifies the final pixel of the frame
- oBusy  out  1  high in SCAN and DRAIN
- oDone  out  1  one-cycle pulse at frame completion

## Operation
- FSM states are IDLE, SCAN, DRAIN and DONE.
- IDLE → SCAN on iStart. The col/row counters clear to 0.
- SCAN: a read is issued in any cycle where the credit check passes.
  - Credit check: in_flight + fifo_count < FIFO_DEPTH. A same-cycle pop is not credited.
  - On issue, a tag {valid=1, col, row, last} enters a READ_LATENCY-deep shift pipeline, and the counters advance.
  - Column counter wraps max→0 and increments the row counter.
  - Issuing (max,max) sets last=1 in the tag and moves the FSM to DRAIN.
- oCol/oRow always equal the counter values and hold while not issuing. The reader's output on non-tagged cycles is ignored.
- When the tag leaves the pipeline with valid=1, {iData, col, row, last} is pushed into the FIFO. The FIFO never overflows, by the credit check.
- FIFO head drives oValid/oPixel/oX/oY/oLast. A pop happens when oValid && iReady.
- DRAIN → DONE once in_flight==0, the FIFO is empty, and the last-tagged pixel has been popped.
- DONE lasts one cycle with oDone=1, then returns to IDLE.
- iStart is ignored outside IDLE.
- oValid deasserts only after a handshake. Payload is stable while oValid && !iReady.
- Reset mid-frame: FSM to IDLE, tag pipeline and FIFO flushed, no further oValid. The next frame needs a fresh iStart.
- Reset values: all outputs 0 (oValid, oPixel, oX, oY, oLast, oBusy, oDone, oCol, oRow).

## Timing
- iStart sampled at cycle 0:
  - State is SCAN at cycle 1, and (0,0) is issued at cycle 1.
  - The tag retires at cycle 1+READ_LATENCY.
  - oValid is first high at cycle 2+READ_LATENCY (cycle 4 with defaults). The FIFO output is registered.
- With iReady held at 1, throughput is 1 pixel/cycle:
  - the last pixel is presented at cycle 65539;
  - oDone pulses at cycle 65540;
  - oBusy is high from cycle 1 through 65539.
- With iReady low, at most FIFO_DEPTH pixels are outstanding, and issue stalls within one cycle.

## Configuration
- SCANNER_FRAME_COUNT_EN defined: adds port oFrameCount (out, 16) and a counter.
  - The counter increments in the DONE cycle and wraps 65535→0.
  - Reset value is 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package (scanner_pkg) holds:
  - the state encodings (IDLE=0, SCAN=1, DRAIN=2, DONE=3);
  - the default WIDTH_BITS/HEIGHT_BITS/READ_LATENCY;
  - the FIFO entry width constant (8+WIDTH_BITS+HEIGHT_BITS+1).
- One sub-module: scan_fifo.
  - Synchronous, parameterised depth/width, show-ahead, registered outputs.
  - Exposes a count output for the credit check.
- The FSM, counters and tag pipeline live in the top module.

## Test plan
- Full frame, iReady=1, ROM model data = (col+row)&0xFF: 65536 beats in raster order; oPixel matches the model at every (oX,oY); oLast only at (255,255); oDone at cycle 65540.
- iReady low cycles 10–30, then random 50% duty: no loss or duplication; payload stable while stalled; in_flight+count never exceeds 4.
- iStart pulsed during SCAN and DONE: ignored, exactly one frame produced; a second iStart in IDLE starts a new frame at (0,0).
- reset asserted at pixel 1000 with the FIFO non-empty: next cycle all outputs 0 and state IDLE; after a new iStart the first pixel is (0,0).
- Row wrap: pixel (255,0) is followed by (0,1) with correct data.
- SCANNER_FRAME_COUNT_EN: three frames → oFrameCount=3; reset → 0.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared constants for the pixel stream scanner: FSM encodings, default
// geometry/latency and the FIFO entry width.
package scanner_pkg;

    localparam int DEFAULT_WIDTH_BITS   = 8;
    localparam int DEFAULT_HEIGHT_BITS  = 8;
    localparam int DEFAULT_READ_LATENCY = 2;

    // FIFO entry is {pixel, col, row, last}
    localparam int FIFO_ENTRY_BITS = 8 + DEFAULT_WIDTH_BITS + DEFAULT_HEIGHT_BITS + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int entry_bits(input int width_bits, input int height_bits);
        return 8 + width_bits + height_bits + 1;
    endfunction

endpackage

// File: rtl/scan_fifo.sv
// Show-ahead synchronous FIFO with registered outputs. Entry 0 of a shifting
// register file is the head, so the payload is a flop and stays put until popped.
module scan_fifo
    import scanner_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_BITS  = FIFO_ENTRY_BITS,
    parameter int COUNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_BITS-1:0]  push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_BITS-1:0]  out_data,
    output logic [COUNT_BITS-1:0] count
);

    logic [DATA_BITS-1:0]  mem      [DEPTH];
    logic [DATA_BITS-1:0]  mem_next [DEPTH];
    logic [COUNT_BITS-1:0] count_next;
    logic [COUNT_BITS-1:0] wr_idx;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != COUNT_BITS'(DEPTH)) || do_pop);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
        end
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_next[i] = mem[i + 1];
            end
        end
        wr_idx = do_pop ? (count - COUNT_BITS'(1)) : count;
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (COUNT_BITS'(i) == wr_idx) begin
                    mem_next[i] = push_data;
                end
            end
        end
        count_next = count + COUNT_BITS'(do_push) - COUNT_BITS'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count     <= count_next;
            out_valid <= (count_next != '0);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

    assign out_data = mem[0];

endmodule

// File: rtl/pixel_stream_scanner.sv
// Raster-scan front end: drives ROM coordinates, tracks read latency with a tag
// pipeline and re-emits pixels through a credit-controlled FIFO.
// Optional feature: define SCANNER_FRAME_COUNT_EN to add the oFrameCount port.
module pixel_stream_scanner
    import scanner_pkg::*;
#(
    parameter int WIDTH_BITS   = DEFAULT_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEFAULT_HEIGHT_BITS,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oCol,
    output logic [HEIGHT_BITS-1:0] oRow,
    input  logic [7:0]             iData,
    output logic                   oValid,
    input  logic                   iReady,
    output logic [7:0]             oPixel,
    output logic [WIDTH_BITS-1:0]  oX,
    output logic [HEIGHT_BITS-1:0] oY,
    output logic                   oLast,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [1:0]             oState
`ifdef SCANNER_FRAME_COUNT_EN
    ,
    output logic [15:0]            oFrameCount
`endif
);

    localparam int ENTRY_BITS = entry_bits(WIDTH_BITS, HEIGHT_BITS);
    localparam int COUNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam logic [WIDTH_BITS-1:0]  COL_MAX = '1;
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX = '1;

    logic [1:0]              state;
    logic [WIDTH_BITS-1:0]   col;
    logic [HEIGHT_BITS-1:0]  row;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_last;
    logic [WIDTH_BITS-1:0]   pipe_col [READ_LATENCY];
    logic [HEIGHT_BITS-1:0]  pipe_row [READ_LATENCY];
    logic [15:0]             in_flight;
    logic [COUNT_BITS-1:0]   fifo_count;
    logic [ENTRY_BITS-1:0]   head;
    logic                    head_valid;
    logic                    head_last;
    logic                    issue;
    logic                    at_end;
    logic                    pop;
    logic                    drain_done;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + 16'(pipe_valid[i]);
        end
    end

    // Credit counts every tag in flight plus every FIFO entry; a pop in the
    // same cycle is not credited, so the FIFO can never overflow.
    assign issue      = (state == ST_SCAN) &&
                        ((in_flight + 16'(fifo_count)) < 16'(FIFO_DEPTH));
    assign at_end     = (col == COL_MAX) && (row == ROW_MAX);
    assign pop        = head_valid && iReady;
    assign drain_done = (in_flight == '0) && (fifo_count == COUNT_BITS'(1)) &&
                        pop && head_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (iStart) state <= ST_SCAN;
                ST_SCAN:  if (issue && at_end) state <= ST_DRAIN;
                ST_DRAIN: if (drain_done) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if ((state == ST_IDLE) && iStart) begin
            col <= '0;
            row <= '0;
        end else if (issue) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + HEIGHT_BITS'(1);
            end else begin
                col <= col + WIDTH_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_col[i] <= '0;
                pipe_row[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_last[0]  <= issue && at_end;
            pipe_col[0]   <= col;
            pipe_row[0]   <= row;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_col[i]   <= pipe_col[i-1];
                pipe_row[i]   <= pipe_row[i-1];
            end
        end
    end

    // Output stream: oValid holds until oValid && iReady; payload is frozen meanwhile.
    scan_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_BITS  (ENTRY_BITS),
        .COUNT_BITS (COUNT_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pipe_valid[READ_LATENCY-1]),
        .push_data ({iData, pipe_col[READ_LATENCY-1], pipe_row[READ_LATENCY-1],
                     pipe_last[READ_LATENCY-1]}),
        .pop       (pop),
        .out_valid (head_valid),
        .out_data  (head),
        .count     (fifo_count)
    );

    assign head_last = head[0];
    assign oValid    = head_valid;
    assign oPixel    = head[ENTRY_BITS-1 -: 8];
    assign oX        = head[HEIGHT_BITS+WIDTH_BITS -: WIDTH_BITS];
    assign oY        = head[HEIGHT_BITS:1];
    assign oLast     = head_valid && head_last;
    assign oCol      = col;
    assign oRow      = row;
    assign oBusy     = (state == ST_SCAN) || (state == ST_DRAIN);
    assign oDone     = (state == ST_DONE);
    assign oState    = state;

`ifdef SCANNER_FRAME_COUNT_EN
    logic [15:0] frame_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state == ST_DONE) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign oFrameCount = frame_count;
`endif

endmodule

// File: tb/tb_pixel_stream_scanner.sv
// Self-checking bench for pixel_stream_scanner on a reduced 32x16 frame, with a
// latency-2 ROM model and a raster-order scoreboard.
module tb_pixel_stream_scanner;

    localparam int XB     = 5;
    localparam int YB     = 4;
    localparam int W      = 1 << XB;
    localparam int H      = 1 << YB;
    localparam int N      = W * H;
    localparam int DEPTH  = 4;
    localparam int EW     = 8 + XB + YB + 1;
    localparam int BUDGET = 4 * N + 200;

    logic          clock = 1'b0;
    logic          reset;
    logic          iStart;
    logic          iReady;
    logic [7:0]    iData;
    logic [XB-1:0] oCol;
    logic [YB-1:0] oRow;
    logic          oValid;
    logic [7:0]    oPixel;
    logic [XB-1:0] oX;
    logic [YB-1:0] oY;
    logic          oLast;
    logic          oBusy;
    logic          oDone;
    logic [1:0]    oState;
`ifdef SCANNER_FRAME_COUNT_EN
    logic [15:0]   oFrameCount;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [EW-1:0] exp_q[$];

    int beats, first_valid, busy_first, busy_last, done_rel, last_rel, state_at1, frame_dones;
    bit done_seen;
    bit stall_prev = 1'b0;
    bit reset_prev = 1'b0;
    logic [EW-1:0] prev_payload;
    logic [7:0] rom_d1, rom_d2;

    pixel_stream_scanner #(
        .WIDTH_BITS   (XB),
        .HEIGHT_BITS  (YB),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .iStart (iStart),
        .oCol   (oCol),
        .oRow   (oRow),
        .iData  (iData),
        .oValid (oValid),
        .iReady (iReady),
        .oPixel (oPixel),
        .oX     (oX),
        .oY     (oY),
        .oLast  (oLast),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oState (oState)
`ifdef SCANNER_FRAME_COUNT_EN
        ,
        .oFrameCount (oFrameCount)
`endif
    );

    // clock / cycle counter / ROM model (data = col+row, two cycles late)
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        rom_d1 <= 8'(int'(oCol) + int'(oRow));
        rom_d2 <= rom_d1;
    end
    assign iData = rom_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] make_entry(input int idx);
        int x, y;
        x = idx % W;
        y = idx / W;
        return {8'(x + y), XB'(x), YB'(y), (idx == N - 1)};
    endfunction

    function automatic logic ready_for(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            if (n < 10) return 1'b1;
            if (n <= 30) return 1'b0;
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic begin_frame();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(make_entry(i));
        beats = 0; first_valid = -1; busy_first = -1; busy_last = -1;
        done_rel = -1; last_rel = -1; state_at1 = -1; frame_dones = 0;
        done_seen = 1'b0;
        t0 = cyc;
        iStart = 1'b1;
    endtask

    task automatic run_frame(input int mode, input bit glitch);
        int n;
        @(posedge clock); #1;
        begin_frame();
        iReady = ready_for(mode, 0);
        n = 0;
        while (!done_seen && n < BUDGET) begin
            @(posedge clock); #1;
            n = cyc - t0;
            iStart = glitch && (n == 50 || n == N + 4);
            iReady = ready_for(mode, n);
        end
        @(posedge clock); #1;
        iStart = 1'b0;
        if (!done_seen) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_valid"}, 32'(oValid), 32'(0));
        check({p, "_pixel"}, 32'(oPixel), 32'(0));
        check({p, "_x"},     32'(oX),     32'(0));
        check({p, "_y"},     32'(oY),     32'(0));
        check({p, "_last"},  32'(oLast),  32'(0));
        check({p, "_busy"},  32'(oBusy),  32'(0));
        check({p, "_done"},  32'(oDone),  32'(0));
        check({p, "_col"},   32'(oCol),   32'(0));
        check({p, "_row"},   32'(oRow),   32'(0));
        check({p, "_state"}, 32'(oState), 32'(0));
    endtask

    // scoreboard / monitor, sampled away from the active edge
    always @(negedge clock) begin
        int rel, issued;
        logic [EW-1:0] payload;
        rel = cyc - t0;
        payload = {oPixel, oX, oY, oLast};
        if (rel == 1) state_at1 = int'(oState);
        if (oValid && first_valid < 0) first_valid = rel;
        if (oBusy) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        if (oDone) begin
            done_rel = rel;
            done_seen = 1'b1;
            frame_dones++;
        end
        if (stall_prev && !reset_prev)
            check("stall_stable", 32'({oValid, payload}), 32'({1'b1, prev_payload}));
        if (oState == 2'd1) issued = int'(oRow) * W + int'(oCol);
        else if (oState == 2'd2) issued = N;
        else issued = -1;
        if (issued >= 0) check("outstanding_le_depth", 32'(issued - beats <= DEPTH), 32'(1));
        if (oValid && iReady) begin
            if (exp_q.size() == 0) check("extra_beat", 32'(1), 32'(0));
            else check("beat", 32'(payload), 32'(exp_q.pop_front()));
            if (oLast) last_rel = rel;
            beats++;
        end
        stall_prev   = oValid && !iReady;
        prev_payload = payload;
        reset_prev   = reset;
    end

    initial begin
        int n;
        bit seen;
        reset = 1'b1; iStart = 1'b0; iReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // full frame at one pixel per cycle: latency and completion timing
        run_frame(0, 1'b0);
        check("state_cycle1", 32'(state_at1), 32'(1));
        check("first_valid_cycle", 32'(first_valid), 32'(4));
        check("busy_first_cycle", 32'(busy_first), 32'(1));
        check("busy_last_cycle", 32'(busy_last), 32'(N + 3));
        check("last_cycle", 32'(last_rel), 32'(N + 3));
        check("done_cycle", 32'(done_rel), 32'(N + 4));
        check("f1_beats", 32'(beats), 32'(N));
        check("f1_q_empty", 32'(exp_q.size()), 32'(0));

        // backpressure: stalled cycles 10..30, then random
        run_frame(1, 1'b0);
        check("f2_beats", 32'(beats), 32'(N));
        check("f2_q_empty", 32'(exp_q.size()), 32'(0));

        // iStart pulsed in SCAN and in DONE must be ignored
        run_frame(0, 1'b1);
        check("f3_beats", 32'(beats), 32'(N));
        check("f3_dones", 32'(frame_dones), 32'(1));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            seen |= oBusy | oValid;
        end
        check("f3_idle_after", 32'(seen), 32'(0));
`ifdef SCANNER_FRAME_COUNT_EN
        check("frame_count_3", 32'(oFrameCount), 32'(3));
`endif

        // reset mid-frame with a non-empty FIFO
        @(posedge clock); #1;
        begin_frame();
        iReady = 1'b1;
        n = 0;
        while (beats < 200 && n < BUDGET) begin
            @(posedge clock); #1;
            n = cyc - t0;
            iStart = 1'b0;
        end
        if (beats < 200) check("midrst_timeout", 32'(0), 32'(1));
        iReady = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("prerst_valid", 32'(oValid), 32'(1));
        reset = 1'b1;
        @(posedge clock); #1;
        check_all_zero("midrst");
        reset = 1'b0;
        exp_q.delete();
        iReady = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            seen |= oValid | oBusy;
        end
        check("postrst_quiet", 32'(seen), 32'(0));
`ifdef SCANNER_FRAME_COUNT_EN
        check("frame_count_rst", 32'(oFrameCount), 32'(0));
`endif

        // fresh frame after reset, random backpressure throughout
        run_frame(2, 1'b0);
        check("f5_beats", 32'(beats), 32'(N));
        check("f5_q_empty", 32'(exp_q.size()), 32'(0));
        check("f5_dones", 32'(frame_dones), 32'(1));
`ifdef SCANNER_FRAME_COUNT_EN
        check("frame_count_1", 32'(oFrameCount), 32'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
